// File: rtl/stdin_uart_pkg.sv
// Shared definitions for the memory-mapped console input peripheral:
// register map, register bit positions, bus store type and receiver state encoding.
package stdin_uart_pkg;

    // Peripheral region base; the console input window sits at +0x40.
    localparam logic [63:0] PERIPHERAL_BASE = 64'h0000_0000_1000_0000;

    // Register offsets inside the 24-byte window.
    localparam logic [63:0] STDIN_DATA_OFF    = 64'd0;
    localparam logic [63:0] STDIN_STATUS_OFF  = 64'd8;
    localparam logic [63:0] STDIN_CTRL_OFF    = 64'd16;
    localparam logic [63:0] STDIN_WINDOW_LAST = 64'd23;

    // DATA register layout.
    localparam int DATA_EMPTY_BIT = 8;

    // STATUS register layout.
    localparam int STATUS_NOT_EMPTY_BIT = 0;
    localparam int STATUS_OVERRUN_BIT   = 1;
    localparam int STATUS_FRAME_ERR_BIT = 2;
    localparam int STATUS_COUNT_LSB     = 8;

    // CTRL register layout.
    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_CLR_ERR_BIT = 1;

    // Core data-bus access type: zero means load, anything else is a store.
    typedef logic [1:0] mem_store_type_t;

    // Serial receiver states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Register decoded from the low address bits.
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_NONE   = 2'd3
    } reg_sel_t;

    // FIFO occupancy shown in an 8-bit field; a full 256-entry FIFO reads as 255.
    function automatic logic [7:0] sat_count8(input logic [8:0] count);
        logic [7:0] result;
        if (count[8]) begin
            result = 8'hFF;
        end else begin
            result = count[7:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/stdin_uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, start-bit validation at mid-bit,
// LSB-first data sampling and stop-bit check. Emits one-cycle pulses per frame.
module stdin_uart_rx
    import stdin_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W - 1){1'b0}}, 1'b1};

    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    rx_state_t        state_r;
    rx_state_t        state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             fall_s;
    logic             tick_s;
    logic             push_s;
    logic             ferr_s;

    // Bring rx into the clock domain and keep the previous value for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign fall_s = prev_r & ~sync2_r;

    // Flag the last cycle of the interval the current state is timing.
    always_comb begin
        tick_s = 1'b0;
        case (state_r)
            START:       tick_s = (cnt_r == HALF_LAST);
            DATA, STOP:  tick_s = (cnt_r == BIT_LAST);
            default:     tick_s = 1'b0;
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a start bit that is high again at mid-bit is a glitch.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (!sync2_r) begin
                        state_next_s = DATA;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (tick_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Frame outcome decided at the stop-bit sample.
    always_comb begin
        push_s = 1'b0;
        ferr_s = 1'b0;
        if ((state_r == STOP) && tick_s) begin
            push_s = sync2_r;
            ferr_s = ~sync2_r;
        end else begin
            push_s = 1'b0;
            ferr_s = 1'b0;
        end
    end

    // Interval counter, data bit index and LSB-first shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            if ((state_r == IDLE) || tick_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (state_r == IDLE) begin
                bit_idx_r <= 3'd0;
            end else if ((state_r == DATA) && tick_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
                shift_r   <= {sync2_r, shift_r[7:1]};
            end
        end
    end

    // Registered frame pulses and received byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_byte    <= 8'd0;
        end else begin
            byte_valid <= push_s;
            frame_err  <= ferr_s;
            if (push_s) begin
                rx_byte <= shift_r;
            end
        end
    end

endmodule

// File: rtl/stdin_uart.sv
// Memory-mapped console input: serial receiver feeding a FIFO, exposed to the
// core as DATA / STATUS / CTRL read-responder registers with a level interrupt.
module stdin_uart
    import stdin_uart_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = PERIPHERAL_BASE + 64'h40,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rx,
    input  logic [63:0]     addr,
    input  mem_store_type_t mem_store_type,
    input  logic            valid,
    input  logic [63:0]     w_data,
    output logic [63:0]     r_data,
    output logic            ready,
    output logic            stdin_taken,
    output logic            rx_interrupt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_COUNT = FIFO_DEPTH[AW:0];

    logic [7:0]  fifo_mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] count_s;
    logic        empty_s;
    logic        full_s;
    logic [7:0]  head_s;

    logic        irq_en_r;
    logic        overrun_r;
    logic        frame_err_r;

    logic [7:0]  rx_byte_s;
    logic        rx_valid_s;
    logic        rx_ferr_s;

    logic [63:0] offset_s;
    reg_sel_t    reg_sel_s;
    logic        accept_s;
    logic        is_load_s;
    logic        pop_s;
    logic        do_push_s;
    logic        overrun_set_s;
    logic        ctrl_wr_s;
    logic        clr_err_s;
    logic [63:0] rdata_next_s;
    logic        unused_wdata_s;

    stdin_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .rx_byte    (rx_byte_s),
        .byte_valid (rx_valid_s),
        .frame_err  (rx_ferr_s)
    );

    // FIFO occupancy from pointers carrying an extra wrap bit.
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign empty_s = (count_s == '0);
    assign full_s  = (count_s == FULL_COUNT);
    assign head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];

    // Address window decode is purely combinational and ignores valid.
    assign offset_s    = addr - BASE_ADDR;
    assign stdin_taken = (addr >= BASE_ADDR) && (offset_s <= STDIN_WINDOW_LAST);
    assign accept_s    = valid & stdin_taken & ~ready;
    assign is_load_s   = (mem_store_type == 2'b00);

    // Only bits [1:0] of a store carry meaning.
    assign unused_wdata_s = ^w_data[63:2];

    // Map the containing 8-byte slot to a register.
    always_comb begin
        reg_sel_s = REG_NONE;
        if (offset_s[4:3] == STDIN_DATA_OFF[4:3]) begin
            reg_sel_s = REG_DATA;
        end else if (offset_s[4:3] == STDIN_STATUS_OFF[4:3]) begin
            reg_sel_s = REG_STATUS;
        end else if (offset_s[4:3] == STDIN_CTRL_OFF[4:3]) begin
            reg_sel_s = REG_CTRL;
        end else begin
            reg_sel_s = REG_NONE;
        end
    end

    // A full FIFO still accepts a push when the same cycle pops.
    assign pop_s         = accept_s & is_load_s & (reg_sel_s == REG_DATA) & ~empty_s;
    assign do_push_s     = rx_valid_s & (~full_s | pop_s);
    assign overrun_set_s = rx_valid_s & full_s & ~pop_s;
    assign ctrl_wr_s     = accept_s & ~is_load_s & (reg_sel_s == REG_CTRL);
    assign clr_err_s     = ctrl_wr_s & w_data[CTRL_CLR_ERR_BIT];

    // Read value for the addressed register; stores return zero.
    always_comb begin
        rdata_next_s = 64'd0;
        if (is_load_s) begin
            case (reg_sel_s)
                REG_DATA: begin
                    if (empty_s) begin
                        rdata_next_s[DATA_EMPTY_BIT] = 1'b1;
                    end else begin
                        rdata_next_s[7:0] = head_s;
                    end
                end
                REG_STATUS: begin
                    rdata_next_s[STATUS_NOT_EMPTY_BIT] = ~empty_s;
                    rdata_next_s[STATUS_OVERRUN_BIT]   = overrun_r;
                    rdata_next_s[STATUS_FRAME_ERR_BIT] = frame_err_r;
                    rdata_next_s[STATUS_COUNT_LSB +: 8] = sat_count8(9'(count_s));
                end
                REG_CTRL: begin
                    rdata_next_s[CTRL_IRQ_EN_BIT] = irq_en_r;
                end
                default: rdata_next_s = 64'd0;
            endcase
        end else begin
            rdata_next_s = 64'd0;
        end
    end

    // Bus response: ready pulses the cycle after acceptance with the captured data.
    always_ff @(posedge clock) begin
        if (reset) begin
            ready  <= 1'b0;
            r_data <= 64'd0;
        end else begin
            ready <= accept_s;
            if (accept_s) begin
                r_data <= rdata_next_s;
            end
        end
    end

    // FIFO read and write pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= rx_byte_s;
        end
    end

    // Interrupt enable and sticky error flags; a new error beats a clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en_r    <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                irq_en_r <= w_data[CTRL_IRQ_EN_BIT];
            end
            overrun_r   <= overrun_set_s | (overrun_r & ~clr_err_s);
            frame_err_r <= rx_ferr_s | (frame_err_r & ~clr_err_s);
        end
    end

    assign rx_interrupt = irq_en_r & ~empty_s;

endmodule
